// File: rtl/vga_pkg.sv
// Shared raster widths, default mode timings and the registered output bundle
// used by the VGA timing generator and its axis counters.
package vga_pkg;

    localparam int COORD_W    = 10;
    localparam int CNT_W      = 11;
    localparam int TOT_W      = CNT_W + 1;
    localparam int DIV_W      = 4;
    localparam int MAX_TOTAL  = 2048;
    localparam int MAX_ACTIVE = 1024;
    localparam int MAX_DIV    = 16;

    // 1024x768@60, pixel clock taken straight from the 64 MHz system clock
    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FP     = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BP     = 160;
    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FP     = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BP     = 29;

    // 640x480@60, nominal 25.175 MHz pixel clock
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef struct packed {
        logic               visible;
        logic               hs;
        logic               vs;
        logic               line_start;
        logic               frame_start;
        logic [COORD_W-1:0] pix_x;
        logic [COORD_W-1:0] pix_y;
    } raster_out_t;

    function automatic logic apply_polarity(input logic level, input logic active_high);
        return active_high ? level : ~level;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus decode of the active
// region and the sync window, all from the current (pre-increment) count.
module vga_axis_counter
    import vga_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [TOT_W-1:0] total_i,
    input  logic [TOT_W-1:0] active_i,
    input  logic [TOT_W-1:0] sync_start_i,
    input  logic [TOT_W-1:0] sync_end_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o,
    output logic             in_active_o,
    output logic             in_sync_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [TOT_W-1:0] cnt_ext;
    logic             at_last;

    assign cnt_ext = {1'b0, cnt_q};
    assign at_last = (cnt_ext == (total_i - TOT_W'(1)));

    assign cnt_o       = cnt_q;
    assign wrap_o      = en_i && at_last;
    assign in_active_o = (cnt_ext < active_i);
    assign in_sync_o   = (cnt_ext >= sync_start_i) && (cnt_ext < sync_end_i);

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator: prescaled pixel tick, horizontal and
// vertical axis counters, and one registered, mutually aligned output set.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = XGA_H_ACTIVE,
    parameter int H_FP     = XGA_H_FP,
    parameter int H_SYNC   = XGA_H_SYNC,
    parameter int H_BP     = XGA_H_BP,
    parameter int V_ACTIVE = XGA_V_ACTIVE,
    parameter int V_FP     = XGA_V_FP,
    parameter int V_SYNC   = XGA_V_SYNC,
    parameter int V_BP     = XGA_V_BP,
    parameter int CLK_DIV  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               polarity,
    output logic               hsync,
    output logic               vsync,
    output logic               visible,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL ||
        H_ACTIVE > MAX_ACTIVE || V_ACTIVE > MAX_ACTIVE ||
        CLK_DIV < 1 || CLK_DIV > MAX_DIV) begin : g_bad_timing
        $error("vga_timing_gen: timing parameters out of range");
    end

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             tick;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap_unused;
    logic             h_act;
    logic             v_act;
    logic             h_sync_win;
    logic             v_sync_win;

    raster_out_t      out_q;
    raster_out_t      out_d;
    logic [7:0]       frame_cnt_q;
    logic [7:0]       frame_cnt_d;
    logic             started_q;
    logic             started_d;
    logic             frame_top;

    assign tick      = (div_cnt_q == DIV_LAST);
    assign div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);

    vga_axis_counter u_h_axis (
        .clk_i        (clk),
        .rst_i        (reset),
        .en_i         (tick),
        .total_i      (TOT_W'(H_TOTAL)),
        .active_i     (TOT_W'(H_ACTIVE)),
        .sync_start_i (TOT_W'(H_ACTIVE + H_FP)),
        .sync_end_i   (TOT_W'(H_ACTIVE + H_FP + H_SYNC)),
        .cnt_o        (h_cnt),
        .wrap_o       (h_wrap),
        .in_active_o  (h_act),
        .in_sync_o    (h_sync_win)
    );

    // The vertical axis only advances on the tick that wraps the horizontal one.
    vga_axis_counter u_v_axis (
        .clk_i        (clk),
        .rst_i        (reset),
        .en_i         (h_wrap),
        .total_i      (TOT_W'(V_TOTAL)),
        .active_i     (TOT_W'(V_ACTIVE)),
        .sync_start_i (TOT_W'(V_ACTIVE + V_FP)),
        .sync_end_i   (TOT_W'(V_ACTIVE + V_FP + V_SYNC)),
        .cnt_o        (v_cnt),
        .wrap_o       (v_wrap_unused),
        .in_active_o  (v_act),
        .in_sync_o    (v_sync_win)
    );

    assign frame_top = (h_cnt == '0) && (v_cnt == '0);

    // Start pulses drop on every non-tick edge so they stay one clk wide.
    always_comb begin
        out_d             = out_q;
        out_d.line_start  = 1'b0;
        out_d.frame_start = 1'b0;
        frame_cnt_d       = frame_cnt_q;
        started_d         = started_q;
        if (tick) begin
            out_d.visible     = h_act && v_act;
            out_d.hs          = h_sync_win;
            out_d.vs          = v_sync_win;
            out_d.line_start  = (h_cnt == '0);
            out_d.frame_start = frame_top;
            out_d.pix_x       = h_act ? h_cnt[COORD_W-1:0] : '0;
            out_d.pix_y       = v_act ? v_cnt[COORD_W-1:0] : '0;
            if (frame_top) begin
                started_d = 1'b1;
                if (started_q) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q   <= '0;
            out_q       <= '0;
            frame_cnt_q <= '0;
            started_q   <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            out_q       <= out_d;
            frame_cnt_q <= frame_cnt_d;
            started_q   <= started_d;
        end
    end

    assign hsync       = apply_polarity(out_q.hs, polarity);
    assign vsync       = apply_polarity(out_q.vs, polarity);
    assign visible     = out_q.visible;
    assign pix_x       = out_q.pix_x;
    assign pix_y       = out_q.pix_y;
    assign line_start  = out_q.line_start;
    assign frame_start = out_q.frame_start;
    assign frame_cnt   = frame_cnt_q;

endmodule
